// File: rtl/univ_cnt_pkg.sv
// univ_cnt_pkg: shared types and encodings for the universal range counter.
//   mode_t        : boundary behaviour, MODE_WRAP (0) / MODE_SAT (1)
//   MODE_*_ENC    : raw encodings, matching the software register map
//   bound_cfg_bad : helper, true when the programmed bounds are inverted (lo > hi)
package univ_cnt_pkg;

  localparam logic MODE_WRAP_ENC = 1'b0;
  localparam logic MODE_SAT_ENC  = 1'b1;

  typedef enum logic {
    MODE_WRAP = MODE_WRAP_ENC,
    MODE_SAT  = MODE_SAT_ENC
  } mode_t;

  // Inverted bounds disable counting; kept as a function so tools and top agree.
  function automatic logic bound_cfg_bad(input logic [31:0] lo, input logic [31:0] hi);
    return lo > hi;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// sat_event_counter: W-bit saturating event counter with synchronous clear.
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset, count <= 0
//   clr   in  synchronous clear, count <= 0
//   inc   in  increment request; ignored once count is all-ones
//   count out registered count
module sat_event_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/univ_range_counter.sv
// univ_range_counter: up/down counter with run-time bounds [lo,hi], programmable
// step and wrap/saturate behaviour on boundary hits.
// Optional feature macro: UNIV_CNT_EVT_COUNT_EN adds the evt_cnt output.
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset (q=0, evt_tick=0)
//   syn_clr  in  synchronous clear, q <= lo
//   load     in  q <= d (not clamped to the range)
//   en       in  count enable
//   up       in  1 = count up, 0 = count down
//   mode     in  MODE_WRAP / MODE_SAT
//   step     in  increment/decrement amount
//   lo, hi   in  inclusive bounds
//   d        in  load value
//   q        out counter value (registered)
//   max_tick out comb, q == hi
//   min_tick out comb, q == lo
//   evt_tick out registered pulse, boundary hit on the previous cycle
//   evt_cnt  out (UNIV_CNT_EVT_COUNT_EN only) saturating count of evt_tick cycles
//   cfg_err  out comb, lo > hi
module univ_range_counter
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syn_clr,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  input  mode_t             mode,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [N-1:0]      d,
  output logic [N-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              evt_tick,
`ifdef UNIV_CNT_EVT_COUNT_EN
  output logic [N-1:0]      evt_cnt,
`endif
  output logic              cfg_err
);

  // One extra bit so q+step and lo+step never alias back into range.
  localparam int unsigned W = N + 1;

  logic [W-1:0] q_x;
  logic [W-1:0] step_x;
  logic [W-1:0] lo_x;
  logic [W-1:0] hi_x;
  logic [W-1:0] sum_x;
  logic [W-1:0] floor_x;
  logic [N-1:0] q_next;
  logic         evt_next;

  assign q_x     = {1'b0, q};
  assign step_x  = W'(step);
  assign lo_x    = {1'b0, lo};
  assign hi_x    = {1'b0, hi};
  assign sum_x   = q_x + step_x;
  assign floor_x = lo_x + step_x;

  assign max_tick = (q == hi);
  assign min_tick = (q == lo);
  assign cfg_err  = bound_cfg_bad(32'(lo), 32'(hi));

  // Next-state: syn_clr > load > en; counting is suppressed by bad bounds or zero step.
  always_comb begin
    q_next   = q;
    evt_next = 1'b0;
    if (syn_clr) begin
      q_next = lo;
    end else if (load) begin
      q_next = d;
    end else if (en && !cfg_err && (step != '0)) begin
      if (up) begin
        if (sum_x <= hi_x) begin
          q_next = q + N'(step);
        end else begin
          evt_next = 1'b1;
          q_next   = (mode == MODE_SAT) ? hi : lo;
        end
      end else begin
        if (q_x >= floor_x) begin
          q_next = q - N'(step);
        end else begin
          evt_next = 1'b1;
          q_next   = (mode == MODE_SAT) ? lo : hi;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      evt_tick <= 1'b0;
    end else begin
      q        <= q_next;
      evt_tick <= evt_next;
    end
  end

`ifdef UNIV_CNT_EVT_COUNT_EN
  // Increment alongside evt_tick so evt_cnt tracks the number of evt_tick cycles.
  sat_event_counter #(
    .W(N)
  ) u_evt_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (syn_clr),
    .inc  (evt_next),
    .count(evt_cnt)
  );
`endif

endmodule

// File: tb/tb_univ_range_counter.sv
// Scoreboard bench for univ_range_counter (N=8, STEP_W=4). The driver applies one
// directed vector per cycle on the falling edge and queues the hand-computed result;
// the monitor pops one entry after each rising edge and compares.
module tb_univ_range_counter;
  import univ_cnt_pkg::*;

  localparam int unsigned N      = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              syn_clr = 1'b0;
  logic              load = 1'b0;
  logic              en = 1'b0;
  logic              up = 1'b1;
  mode_t             mode = MODE_WRAP;
  logic [STEP_W-1:0] step = '0;
  logic [N-1:0]      lo = '0;
  logic [N-1:0]      hi = '0;
  logic [N-1:0]      d = '0;
  logic [N-1:0]      q;
  logic              max_tick;
  logic              min_tick;
  logic              evt_tick;
  logic              cfg_err;
`ifdef UNIV_CNT_EVT_COUNT_EN
  logic [N-1:0]      evt_cnt;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    string nm;
    int    q;
    int    evt;
    int    mx;
    int    mn;
    int    ce;
    int    ec;
  } exp_t;

  exp_t sb[$];

  univ_range_counter #(.N(N), .STEP_W(STEP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .syn_clr (syn_clr),
    .load    (load),
    .en      (en),
    .up      (up),
    .mode    (mode),
    .step    (step),
    .lo      (lo),
    .hi      (hi),
    .d       (d),
    .q       (q),
    .max_tick(max_tick),
    .min_tick(min_tick),
    .evt_tick(evt_tick),
`ifdef UNIV_CNT_EVT_COUNT_EN
    .evt_cnt (evt_cnt),
`endif
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  // One cycle of stimulus; expected values are the state after the next rising edge.
  task automatic cyc(input string nm, input bit rs, input bit sc, input bit ld,
                     input bit e, input bit u, input bit m, input int st,
                     input int l, input int h, input int dd,
                     input int eq, input int ee, input int ec);
    exp_t x;
    @(negedge clk);
    reset   = rs;
    syn_clr = sc;
    load    = ld;
    en      = e;
    up      = u;
    mode    = m ? MODE_SAT : MODE_WRAP;
    step    = STEP_W'(st);
    lo      = N'(l);
    hi      = N'(h);
    d       = N'(dd);
    x.nm  = nm;
    x.q   = eq;
    x.evt = ee;
    x.mx  = (eq == h) ? 1 : 0;
    x.mn  = (eq == l) ? 1 : 0;
    x.ce  = (l > h) ? 1 : 0;
    x.ec  = ec;
    sb.push_back(x);
  endtask

  // Monitor: every cycle presents a result, so pop and compare after each edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk(x.nm, "q", int'(q), x.q);
        chk(x.nm, "evt_tick", int'(evt_tick), x.evt);
        chk(x.nm, "max_tick", int'(max_tick), x.mx);
        chk(x.nm, "min_tick", int'(min_tick), x.mn);
        chk(x.nm, "cfg_err", int'(cfg_err), x.ce);
`ifdef UNIV_CNT_EVT_COUNT_EN
        chk(x.nm, "evt_cnt", int'(evt_cnt), x.ec);
`endif
      end
    end
  end

  initial begin : driver
    //   name          rs sc ld en up sat st  lo   hi  d    q  evt ec
    cyc("reset",        1, 0, 0, 0, 1, 0, 0, 10,  20, 0,   0, 0, 0);
    // up, wrap, step 3
    cyc("wrap_clr",     0, 1, 0, 0, 1, 0, 3, 10,  20, 0,  10, 0, 0);
    cyc("wrap_13",      0, 0, 0, 1, 1, 0, 3, 10,  20, 0,  13, 0, 0);
    cyc("wrap_16",      0, 0, 0, 1, 1, 0, 3, 10,  20, 0,  16, 0, 0);
    cyc("wrap_19",      0, 0, 0, 1, 1, 0, 3, 10,  20, 0,  19, 0, 0);
    cyc("wrap_to_lo",   0, 0, 0, 1, 1, 0, 3, 10,  20, 0,  10, 1, 1);
    cyc("wrap_13b",     0, 0, 0, 1, 1, 0, 3, 10,  20, 0,  13, 0, 1);
    cyc("idle",         0, 0, 0, 0, 1, 0, 3, 10,  20, 0,  13, 0, 1);
    // up, saturate
    cyc("sat_clr",      0, 1, 0, 0, 1, 1, 3, 10,  20, 0,  10, 0, 0);
    cyc("sat_13",       0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  13, 0, 0);
    cyc("sat_16",       0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  16, 0, 0);
    cyc("sat_19",       0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  19, 0, 0);
    cyc("sat_hit",      0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  20, 1, 1);
    cyc("sat_stick1",   0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  20, 1, 2);
    cyc("sat_stick2",   0, 0, 0, 1, 1, 1, 3, 10,  20, 0,  20, 1, 3);
    cyc("sat_idle",     0, 0, 0, 0, 1, 1, 3, 10,  20, 0,  20, 0, 3);
    // down, wrap, step 4 from 12
    cyc("dn_load",      0, 0, 1, 0, 0, 0, 4, 10,  20, 12, 12, 0, 3);
    cyc("dn_wrap",      0, 0, 0, 1, 0, 0, 4, 10,  20, 0,  20, 1, 4);
    cyc("dn_16",        0, 0, 0, 1, 0, 0, 4, 10,  20, 0,  16, 0, 4);
    cyc("dn_12",        0, 0, 0, 1, 0, 0, 4, 10,  20, 0,  12, 0, 4);
    cyc("dn_wrap2",     0, 0, 0, 1, 0, 0, 4, 10,  20, 0,  20, 1, 5);
    // full 8-bit range: 250+15 must not alias to 9
    cyc("full_load",    0, 0, 1, 0, 1, 0, 15, 0, 255, 250, 250, 0, 5);
    cyc("full_wrap",    0, 0, 0, 1, 1, 0, 15, 0, 255, 0,    0, 1, 6);
    cyc("full_15",      0, 0, 0, 1, 1, 0, 15, 0, 255, 0,   15, 0, 6);
    cyc("full_ld_sat",  0, 0, 1, 0, 1, 1, 15, 0, 255, 250, 250, 0, 6);
    cyc("full_sat",     0, 0, 0, 1, 1, 1, 15, 0, 255, 0,  255, 1, 7);
    // inverted bounds: counting blocked, load/syn_clr still act
    cyc("cfg_hold",     0, 0, 0, 1, 1, 0, 3, 30,  20, 0,  255, 0, 7);
    cyc("cfg_load",     0, 0, 1, 0, 1, 0, 3, 30,  20, 5,    5, 0, 7);
    cyc("cfg_hold2",    0, 0, 0, 1, 0, 0, 3, 30,  20, 0,    5, 0, 7);
    cyc("cfg_clr",      0, 1, 0, 0, 1, 0, 3, 30,  20, 0,   30, 0, 0);
    // priority and zero step
    cyc("prio_all",     0, 1, 1, 1, 1, 0, 3, 10,  20, 17,  10, 0, 0);
    cyc("prio_ld_en",   0, 0, 1, 1, 1, 0, 3, 10,  20, 15,  15, 0, 0);
    cyc("step0",        0, 0, 0, 1, 1, 0, 0, 10,  20, 0,   15, 0, 0);
    // out-of-range starting points
    cyc("oor_ld_hi",    0, 0, 1, 0, 1, 0, 1, 10,  20, 25,  25, 0, 0);
    cyc("oor_up",       0, 0, 0, 1, 1, 0, 1, 10,  20, 0,   10, 1, 1);
    cyc("oor_ld_lo",    0, 0, 1, 0, 0, 0, 2, 10,  20, 3,    3, 0, 1);
    cyc("oor_dn",       0, 0, 0, 1, 0, 0, 2, 10,  20, 0,   20, 1, 2);
    // down saturate held at lo
    cyc("dsat_clr",     0, 1, 0, 0, 0, 1, 1, 10,  20, 0,   10, 0, 0);
    cyc("dsat_1",       0, 0, 0, 1, 0, 1, 1, 10,  20, 0,   10, 1, 1);
    cyc("dsat_2",       0, 0, 0, 1, 0, 1, 1, 10,  20, 0,   10, 1, 2);
    // three wraps, then syn_clr clears the event count
    cyc("w3_clr",       0, 1, 0, 0, 1, 0, 5, 10,  20, 0,   10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("w3_15",      0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   15, 0, i);
      cyc("w3_20",      0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   20, 0, i);
      cyc("w3_wrap",    0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   10, 1, i + 1);
    end
    cyc("w3_clr2",      0, 1, 0, 0, 1, 0, 5, 10,  20, 0,   10, 0, 0);
    // reset beats load/en and kills a pending pulse
    cyc("r_15",         0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   15, 0, 0);
    cyc("r_20",         0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   20, 0, 0);
    cyc("r_wrap",       0, 0, 0, 1, 1, 0, 5, 10,  20, 0,   10, 1, 1);
    cyc("r_mid",        1, 0, 1, 1, 1, 0, 5, 10,  20, 9,    0, 0, 0);
    cyc("r_after",      0, 0, 0, 1, 1, 0, 5, 10,  20, 0,    5, 0, 0);

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
